effects_ctrl: RTL and testbench

Control-plane sequencer for the per-channel effects chain (delay, echo, distortion, limiter). It accepts UI commands over a valid/ready handshake and owns the per-channel effect enable bits, per-channel output gain and the global limiter threshold. Enable toggles are click-free: the target channel's gain ramps to zero, the enable flips, then the gain ramps back to unity. All register updates are aligned to the audio sample_tick. The block sits between the UI/button decoder and the effects chain plus its output gain stage.

---
 rtl/effects_ctrl.sv | 136 +++++++++++++
 tb/tb_effects_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/effects_ctrl.sv
// Effects-chain control sequencer: owns per-channel effect enables, output gains
// and the limiter threshold, with click-free enable toggles aligned to sample_tick.
module effects_ctrl #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned GAIN_W        = 8,
  parameter int unsigned RAMP_STEP     = 32,
  parameter logic [7:0]  LIMIT_DEFAULT = 8'h7C,
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       sample_tick,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_op,
  input  logic [CH_W-1:0]            cmd_channel,
  input  logic [2:0]                 cmd_effect,
  input  logic [7:0]                 cmd_limit,
  output logic [CHANNELS-1:0]        delay_en,
  output logic [CHANNELS-1:0]        echo_en,
  output logic [CHANNELS-1:0]        distortion_en,
  output logic [CHANNELS-1:0]        limiter_en,
  output logic [CHANNELS*GAIN_W-1:0] gain,
  output logic [7:0]                 limit,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  typedef enum logic [2:0] {
    S_IDLE, S_RAMP_DOWN, S_SWITCH, S_RAMP_UP, S_LIMIT_WAIT
  } state_t;

  localparam logic [GAIN_W-1:0] GAIN_MAX = '1;
  localparam logic [GAIN_W:0]   STEP_X   = (GAIN_W+1)'(RAMP_STEP);

  state_t              state_q;
  logic [CH_W-1:0]     ch_q;
  logic [1:0]          eff_q;
  logic [7:0]          lim_cap_q;
  logic [7:0]          limit_q;
  logic                done_q;
  logic                err_q;
  logic [GAIN_W-1:0]   gain_q [CHANNELS];
  logic [CHANNELS-1:0] en_q [4];

  logic [GAIN_W:0]     cur_x, sum_x, dif_x;
  logic [GAIN_W-1:0]   gain_dn_d, gain_up_d;

  // Ramp arithmetic is one bit wider so both directions saturate instead of wrapping.
  always_comb begin
    cur_x     = {1'b0, gain_q[ch_q]};
    sum_x     = cur_x + STEP_X;
    dif_x     = cur_x - STEP_X;
    gain_up_d = (sum_x > {1'b0, GAIN_MAX}) ? GAIN_MAX : sum_x[GAIN_W-1:0];
    gain_dn_d = (cur_x < STEP_X) ? '0 : dif_x[GAIN_W-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      eff_q     <= '0;
      lim_cap_q <= '0;
      limit_q   <= LIMIT_DEFAULT;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < CHANNELS; i++) gain_q[i] <= GAIN_MAX;
      for (int unsigned e = 0; e < 4; e++) en_q[e] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op) begin
              lim_cap_q <= cmd_limit;
              state_q   <= S_LIMIT_WAIT;
            end else if (cmd_effect[2]) begin
              err_q <= 1'b1;
            end else begin
              ch_q    <= cmd_channel;
              eff_q   <= cmd_effect[1:0];
              state_q <= S_RAMP_DOWN;
            end
          end
        end
        S_RAMP_DOWN: begin
          if (sample_tick) begin
            gain_q[ch_q] <= gain_dn_d;
            if (gain_dn_d == '0) state_q <= S_SWITCH;
          end
        end
        S_SWITCH: begin
          if (sample_tick) begin
            en_q[eff_q][ch_q] <= ~en_q[eff_q][ch_q];
            state_q           <= S_RAMP_UP;
          end
        end
        S_RAMP_UP: begin
          if (sample_tick) begin
            gain_q[ch_q] <= gain_up_d;
            if (gain_up_d == GAIN_MAX) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        S_LIMIT_WAIT: begin
          if (sample_tick) begin
            limit_q <= lim_cap_q;
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    gain = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) gain[i*GAIN_W +: GAIN_W] = gain_q[i];
  end

  assign cmd_ready     = (state_q == S_IDLE) && !rst_in;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err           = err_q;
  assign limit         = limit_q;
  assign delay_en      = en_q[0];
  assign echo_en       = en_q[1];
  assign distortion_en = en_q[2];
  assign limiter_en    = en_q[3];

endmodule

// File: tb/tb_effects_ctrl.sv
// Directed bench for effects_ctrl: a reference model fills a scoreboard queue per
// command and each sample_tick pops one expected gain/enable/done step.
module tb_effects_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        sample_tick = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [1:0]  cmd_channel = '0;
  logic [2:0]  cmd_effect = '0;
  logic [7:0]  cmd_limit = '0;
  logic [3:0]  delay_en, echo_en, distortion_en, limiter_en;
  logic [31:0] gain;
  logic [7:0]  limit;
  logic        busy, done, err;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_done   = 0;

  typedef struct {
    logic [7:0] g;
    logic       en;
    logic       dn;
  } step_t;
  step_t exp_q [$];

  logic [7:0] m_gain [4];
  logic [3:0] m_en   [4];
  logic [7:0] m_limit;

  effects_ctrl #(.CHANNELS(4), .GAIN_W(8), .RAMP_STEP(32), .LIMIT_DEFAULT(8'h7C)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_tick(sample_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_channel(cmd_channel), .cmd_effect(cmd_effect), .cmd_limit(cmd_limit),
    .delay_en(delay_en), .echo_en(echo_en), .distortion_en(distortion_en),
    .limiter_en(limiter_en), .gain(gain), .limit(limit),
    .busy(busy), .done(done), .err(err)
  );

  initial forever #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] dut_en(input int e);
    case (e)
      0: return delay_en;
      1: return echo_en;
      2: return distortion_en;
      default: return limiter_en;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_gain[i] = 8'hFF;
      m_en[i]   = 4'h0;
    end
    m_limit = 8'h7C;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "/gain"}, gain, {m_gain[3], m_gain[2], m_gain[1], m_gain[0]});
    for (int e = 0; e < 4; e++) chk({tag, "/en"}, dut_en(e), m_en[e]);
    chk({tag, "/limit"}, limit, m_limit);
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Reference ramp: saturating down by 32 to 0, flip, saturating up by 32 to 255.
  task automatic push_toggle(input int ch, input int eff);
    int   g;
    logic en;
    g  = m_gain[ch];
    en = m_en[eff][ch];
    while (g != 0) begin
      g = (g >= 32) ? g - 32 : 0;
      exp_q.push_back('{g[7:0], en, 1'b0});
    end
    en = ~en;
    exp_q.push_back('{8'd0, en, 1'b0});
    while (g != 255) begin
      g = (g + 32 > 255) ? 255 : g + 32;
      exp_q.push_back('{g[7:0], en, (g == 255)});
    end
  endtask

  task automatic issue(input logic op, input int ch, input int eff,
                       input logic [7:0] lim, input logic with_tick);
    cmd_op = op; cmd_channel = ch[1:0]; cmd_effect = eff[2:0]; cmd_limit = lim;
    cmd_valid = 1'b1; sample_tick = with_tick;
    chk("ready_before_accept", cmd_ready, 1'b1);
    cyc();
    sample_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n, input int ch, input int eff, input int gap);
    step_t s;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 0, 1);
        return;
      end
      s = exp_q.pop_front();
      sample_tick = 1'b1;
      cyc();
      sample_tick = 1'b0;
      m_gain[ch] = s.g;
      m_en[eff][ch] = s.en;
      chk_all("tick");
      chk("tick/done", done, s.dn);
      chk("tick/busy", busy, !s.dn);
      chk("tick/ready", cmd_ready, s.dn);
      if (done) n_done++;
      if (gap > 1) begin
        cyc();
        chk("gap/done_low", done, 1'b0);
        chk("gap/gain_hold", gain, {m_gain[3], m_gain[2], m_gain[1], m_gain[0]});
        for (int i = 2; i < gap; i++) cyc();
      end
    end
  endtask

  initial begin
    model_reset();
    // Reset
    rst_in = 1'b1;
    cyc();
    chk("ready_in_reset", cmd_ready, 1'b0);
    cyc();
    rst_in = 1'b0;
    #1;
    chk_all("reset");
    chk("reset/ready", cmd_ready, 1'b1);
    chk("reset/busy", busy, 1'b0);
    chk("reset/done", done, 1'b0);
    chk("reset/err", err, 1'b0);

    // Delay toggle on ch2; tick in the acceptance cycle must not count
    push_toggle(2, 0);
    issue(1'b0, 2, 0, 8'h00, 1'b1);
    cmd_valid = 1'b0;
    chk("accept/busy", busy, 1'b1);
    chk("accept/ready", cmd_ready, 1'b0);
    chk_all("accept_tick_ignored");
    for (int i = 0; i < 255; i++) cyc();
    run_ticks(17, 2, 0, 256);
    chk("ch2/queue_drained", exp_q.size(), 0);
    chk("ch2/done_count", n_done, 1);

    // Set limit; valid kept high with a different value while busy
    issue(1'b1, 0, 0, 8'h40, 1'b0);
    cmd_limit = 8'h11;
    for (int i = 0; i < 3; i++) begin
      chk("limit_wait/busy", busy, 1'b1);
      chk("limit_wait/limit", limit, 8'h7C);
      cyc();
    end
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cmd_valid = 1'b0;
    m_limit = 8'h40;
    chk_all("limit_set");
    chk("limit_set/done", done, 1'b1);
    chk("limit_set/busy", busy, 1'b0);
    cyc();
    chk("limit_after/done", done, 1'b0);
    chk("limit_after/busy", busy, 1'b0);
    chk("limit_after/limit", limit, 8'h40);

    // Illegal effect code
    issue(1'b0, 1, 5, 8'h00, 1'b0);
    cmd_valid = 1'b0;
    chk("illegal/err", err, 1'b1);
    chk("illegal/done", done, 1'b0);
    chk("illegal/busy", busy, 1'b0);
    chk("illegal/ready", cmd_ready, 1'b1);
    chk_all("illegal");
    cyc();
    chk("illegal/err_once", err, 1'b0);
    chk("illegal/busy_after", busy, 1'b0);

    // Back-to-back echo toggles on ch0 with the second command held while busy
    n_done = 0;
    push_toggle(0, 1);
    issue(1'b0, 0, 1, 8'h00, 1'b0);
    run_ticks(17, 0, 1, 1);
    chk("b2b/done_cycle_ready", cmd_ready, 1'b1);
    push_toggle(0, 1);
    cyc();
    cmd_valid = 1'b0;
    chk("b2b/second_accepted", busy, 1'b1);
    chk("b2b/done_low", done, 1'b0);
    run_ticks(17, 0, 1, 4);
    chk("b2b/echo_en0", echo_en[0], 1'b0);
    chk("b2b/done_count", n_done, 2);

    // Reset during RAMP_UP once gain[1] has reached 96
    n_done = 0;
    push_toggle(1, 2);
    issue(1'b0, 1, 2, 8'h00, 1'b0);
    cmd_valid = 1'b0;
    run_ticks(12, 1, 2, 3);
    chk("midreset/gain1_96", gain[15:8], 8'd96);
    chk("midreset/dist_en1", distortion_en[1], 1'b1);
    exp_q.delete();
    rst_in = 1'b1;
    #1;
    chk("midreset/ready_low", cmd_ready, 1'b0);
    cyc();
    rst_in = 1'b0;
    model_reset();
    chk_all("midreset");
    chk("midreset/busy", busy, 1'b0);
    chk("midreset/done", done, 1'b0);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    chk_all("midreset_after_tick");
    chk("midreset/no_done", done, 1'b0);
    chk("midreset/ready", cmd_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
